// File: rtl/xls_add_tree_pipe.sv
// Pipelined NUM_IN-operand adder tree with valid/ready flow control.
// Stage 0 registers the sign/zero-extended lanes; each following stage is one registered tree level.
module xls_add_tree_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_ovf
);

    localparam int LVL = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
    localparam int SW  = WIDTH + LVL;
    localparam int NS  = LVL + 1;

    logic [NS-1:0] valid_q;
    logic [NS-1:0] stageLoad;
    logic          loadAcc;
    logic [SW-1:0] part_q [NS][NUM_IN];
    logic [SW-1:0] part_d [NS][NUM_IN];

    function automatic int cntAt(input int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    function automatic logic [SW-1:0] extendLane(input logic [WIDTH-1:0] lane);
        if (MODE == 2) begin
            return SW'($signed(lane));
        end
        return SW'(lane);
    endfunction

    // A stage may load when it or any stage downstream of it is empty, or the sink takes a result.
    always_comb begin
        loadAcc = out_ready;
        for (int s = NS - 1; s >= 0; s--) begin
            loadAcc      = loadAcc | ~valid_q[s];
            stageLoad[s] = loadAcc;
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                part_d[k][j] = '0;
            end
        end
        for (int j = 0; j < NUM_IN; j++) begin
            part_d[0][j] = extendLane(in_data[j*WIDTH +: WIDTH]);
        end
        // An odd trailing element is passed through first, then overwritten wherever a pair exists.
        for (int k = 1; k <= LVL; k++) begin
            for (int j = 0; j < (NUM_IN + 1) / 2; j++) begin
                if (2 * j < cntAt(k - 1)) begin
                    part_d[k][j] = part_q[k-1][2*j];
                end
            end
            for (int j = 0; j < NUM_IN / 2; j++) begin
                if (2 * j + 1 < cntAt(k - 1)) begin
                    part_d[k][j] = part_q[k-1][2*j] + part_q[k-1][2*j+1];
                end
            end
        end
    end

    // Data is only captured from a valid source so an empty slot never poisons a valid one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < NS; k++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    part_q[k][j] <= '0;
                end
            end
        end else begin
            if (stageLoad[0]) begin
                valid_q[0] <= in_valid;
            end
            if (stageLoad[0] && in_valid) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    part_q[0][j] <= part_d[0][j];
                end
            end
            for (int s = 1; s < NS; s++) begin
                if (stageLoad[s]) begin
                    valid_q[s] <= valid_q[s-1];
                end
                if (stageLoad[s] && valid_q[s-1]) begin
                    for (int j = 0; j < NUM_IN; j++) begin
                        part_q[s][j] <= part_d[s][j];
                    end
                end
            end
        end
    end

    assign in_ready  = stageLoad[0];
    assign out_valid = valid_q[NS-1];

    if (LVL == 0) begin : gPassThrough
        assign out_data = part_q[0][0][WIDTH-1:0];
        assign out_ovf  = 1'b0;
    end else begin : gResolve
        logic [SW-1:0] finalSum;
        logic          upperAny;
        logic          posClamp;
        logic          negClamp;

        assign finalSum = part_q[LVL][0];
        assign upperAny = |finalSum[SW-1:WIDTH];
        // Signed range check: the bits above the result sign must all echo the true sign.
        assign posClamp = ~finalSum[SW-1] & (|finalSum[SW-2:WIDTH-1]);
        assign negClamp = finalSum[SW-1] & ~(&finalSum[SW-2:WIDTH-1]);

        always_comb begin
            out_data = finalSum[WIDTH-1:0];
            out_ovf  = 1'b0;
            if (MODE == 1) begin
                if (upperAny) begin
                    out_data = '1;
                    out_ovf  = 1'b1;
                end
            end else if (MODE == 2) begin
                if (posClamp) begin
                    out_data = {1'b0, {(WIDTH-1){1'b1}}};
                    out_ovf  = 1'b1;
                end else if (negClamp) begin
                    out_data = {1'b1, {(WIDTH-1){1'b0}}};
                    out_ovf  = 1'b1;
                end
            end else begin
                out_ovf = upperAny;
            end
        end
    end

endmodule

// File: tb/tb_xls_add_tree_pipe.sv
// Bench for xls_add_tree_pipe: seven parameter sets share one lane bus, each checked against
// an arithmetic model of the sum rules plus hand-computed literal results.
module tb_xls_add_tree_pipe;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic [6:0]       inValid    = '0;
    logic             outReady   = 1'b1;
    logic             forceReady = 1'b1;
    logic             randReady  = 1'b0;
    logic [4:0][31:0] laneBus    = '0;
    wire  [6:0]       inReady;
    wire  [6:0]       outValid;
    wire  [6:0]       outOvf;
    wire  [31:0]      d0Data;
    wire  [7:0]       d1Data, d2Data, d3Data;
    wire  [15:0]      d4Data, d5Data, d6Data;
    logic [31:0]      outData [7];

    int               vectors     = 0;
    int               miscompares = 0;
    int               cyc         = 0;
    logic [32:0]      expQ [7][$];

    assign outData[0] = d0Data;
    assign outData[1] = {24'd0, d1Data};
    assign outData[2] = {24'd0, d2Data};
    assign outData[3] = {24'd0, d3Data};
    assign outData[4] = {16'd0, d4Data};
    assign outData[5] = {16'd0, d5Data};
    assign outData[6] = {16'd0, d6Data};

    xls_add_tree_pipe #(.WIDTH(32), .NUM_IN(3), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data({laneBus[2], laneBus[1], laneBus[0]}),
        .out_valid(outValid[0]), .out_ready(outReady), .out_data(d0Data), .out_ovf(outOvf[0]));
    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(3), .MODE(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data({laneBus[2][7:0], laneBus[1][7:0], laneBus[0][7:0]}),
        .out_valid(outValid[1]), .out_ready(outReady), .out_data(d1Data), .out_ovf(outOvf[1]));
    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(3), .MODE(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data({laneBus[2][7:0], laneBus[1][7:0], laneBus[0][7:0]}),
        .out_valid(outValid[2]), .out_ready(outReady), .out_data(d2Data), .out_ovf(outOvf[2]));
    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(3), .MODE(2)) u3 (
        .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(inReady[3]),
        .in_data({laneBus[2][7:0], laneBus[1][7:0], laneBus[0][7:0]}),
        .out_valid(outValid[3]), .out_ready(outReady), .out_data(d3Data), .out_ovf(outOvf[3]));
    xls_add_tree_pipe #(.WIDTH(16), .NUM_IN(1), .MODE(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(inValid[4]), .in_ready(inReady[4]),
        .in_data(laneBus[0][15:0]),
        .out_valid(outValid[4]), .out_ready(outReady), .out_data(d4Data), .out_ovf(outOvf[4]));
    xls_add_tree_pipe #(.WIDTH(16), .NUM_IN(4), .MODE(2)) u5 (
        .clk(clk), .rst(rst), .in_valid(inValid[5]), .in_ready(inReady[5]),
        .in_data({laneBus[3][15:0], laneBus[2][15:0], laneBus[1][15:0], laneBus[0][15:0]}),
        .out_valid(outValid[5]), .out_ready(outReady), .out_data(d5Data), .out_ovf(outOvf[5]));
    xls_add_tree_pipe #(.WIDTH(16), .NUM_IN(5), .MODE(0)) u6 (
        .clk(clk), .rst(rst), .in_valid(inValid[6]), .in_ready(inReady[6]),
        .in_data({laneBus[4][15:0], laneBus[3][15:0], laneBus[2][15:0], laneBus[1][15:0], laneBus[0][15:0]}),
        .out_valid(outValid[6]), .out_ready(outReady), .out_data(d6Data), .out_ovf(outOvf[6]));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream readiness is either forced or randomised, updated shortly after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        outReady = randReady ? ($urandom_range(0, 1) == 1) : forceReady;
    end

    function automatic int cfgW(input int d);
        case (d)
            0:       return 32;
            1, 2, 3: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfgN(input int d);
        case (d)
            4:       return 1;
            5:       return 4;
            6:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int cfgM(input int d);
        case (d)
            2, 4:    return 1;
            3, 5:    return 2;
            default: return 0;
        endcase
    endfunction

    // True mathematical sum of the lanes, then clamped or wrapped into WIDTH bits.
    function automatic logic [32:0] modelOf(input int d, input logic [4:0][31:0] lanes);
        longint mask, sum, lane, maxS, minS, res;
        logic   ovf;
        int     w;
        w    = cfgW(d);
        mask = (longint'(1) << w) - 1;
        maxS = (longint'(1) << (w - 1)) - 1;
        minS = -(maxS + 1);
        sum  = 0;
        ovf  = 1'b0;
        for (int i = 0; i < cfgN(d); i++) begin
            lane = longint'(lanes[i]) & mask;
            if (cfgM(d) == 2 && lane[w-1]) begin
                lane = lane - (mask + 1);
            end
            sum += lane;
        end
        if (cfgN(d) == 1) begin
            res = longint'(lanes[0]) & mask;
        end else if (cfgM(d) == 0) begin
            res = sum & mask;
            ovf = (sum > mask);
        end else if (cfgM(d) == 1) begin
            res = (sum > mask) ? mask : sum;
            ovf = (sum > mask);
        end else if (sum > maxS) begin
            res = maxS;
            ovf = 1'b1;
        end else if (sum < minS) begin
            res = minS & mask;
            ovf = 1'b1;
        end else begin
            res = sum & mask;
        end
        return {ovf, res[31:0]};
    endfunction

    function automatic logic [4:0][31:0] mk(input logic [31:0] a, input logic [31:0] b = 0,
                                             input logic [31:0] c = 0, input logic [31:0] e = 0,
                                             input logic [31:0] f = 0);
        logic [4:0][31:0] r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = e;
        r[4] = f;
        return r;
    endfunction

    function automatic logic [4:0][31:0] randLanes();
        logic [4:0][31:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = $urandom;
        end
        return r;
    endfunction

    // Every cycle: each presented result must equal the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            for (int d = 0; d < 7; d++) begin
                expQ[d].delete();
            end
        end else begin
            for (int d = 0; d < 7; d++) begin
                if (outValid[d]) begin
                    vectors++;
                    if (expQ[d].size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL spurious-result dut%0d: got ovf=%b data=%h, required no valid result",
                                 d, outOvf[d], outData[d]);
                    end else begin
                        if ({outOvf[d], outData[d]} !== expQ[d][0]) begin
                            miscompares++;
                            $display("[TB] FAIL stream-result dut%0d: got ovf=%b data=%h, required ovf=%b data=%h",
                                     d, outOvf[d], outData[d], expQ[d][0][32], expQ[d][0][31:0]);
                        end
                        if (outReady) begin
                            void'(expQ[d].pop_front());
                        end
                    end
                end
                if (inValid[d] && inReady[d]) begin
                    expQ[d].push_back(modelOf(d, laneBus));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [32:0] got, input logic [32:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Presents one operand set to one instance and returns just after the accepting edge.
    task automatic applyStimulus(input int d, input logic [4:0][31:0] lanes);
        int waitCnt;
        waitCnt    = 0;
        laneBus    = lanes;
        inValid[d] = 1'b1;
        @(negedge clk);
        while (!inReady[d] && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReady[d]) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept-timeout dut%0d: got in_ready=0, required acceptance within 200 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int d, input logic [31:0] expData,
                               input logic expOvf, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!outValid[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!outValid[d]) begin
            miscompares++;
            $display("[TB] FAIL %s: got no out_valid, required a result within %0d cycles", name, budget);
        end else if ({outOvf[d], outData[d]} !== {expOvf, expData}) begin
            miscompares++;
            $display("[TB] FAIL %s: got ovf=%b data=%h, required ovf=%b data=%h",
                     name, outOvf[d], outData[d], expOvf, expData);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        inValid = '0;
        repeat (n) begin
            laneBus = randLanes();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic streamRandom(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(d, randLanes());
        end
        inValid[d] = 1'b0;
    endtask

    initial begin
        int c0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 7; d++) begin
            checkVal($sformatf("reset-state-dut%0d", d), {outValid[d], outOvf[d], outData[d][30:0]}, '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("in-ready-after-reset", 33'(inReady), 33'h7F);
        @(posedge clk);
        #1;

        checkVal("model-pin-123", modelOf(0, mk(1, 2, 3)), {1'b0, 32'd6});
        checkVal("model-pin-s8-zero", modelOf(3, mk(32'h80, 32'h7F, 32'h01)), {1'b0, 32'h0});
        checkVal("model-pin-n4-negclamp", modelOf(5, mk(32'h8000, 32'h8000)), {1'b1, 32'h8000});
        checkVal("model-pin-n5-wrap", modelOf(6, mk(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF)), {1'b1, 32'hFFFB});
        checkVal("model-pin-n1-pass", modelOf(4, mk(32'h1234ABCD)), {1'b0, 32'hABCD});

        // Latency: result appears exactly three cycles after the accepting cycle.
        applyStimulus(0, mk(1, 2, 3));
        inValid[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkVal($sformatf("latency-cycle%0d", c), 33'(outValid[0]), 33'(c == 3));
        end
        checkVal("sum-1-2-3", {outOvf[0], outData[0]}, {1'b0, 32'd6});
        @(posedge clk);
        #1;

        c0 = cyc;
        streamRandom(0, 100);
        checkVal("stream-throughput", 33'(cyc - c0), 33'd100);
        idle(6);

        // Fill the pipe with the sink stalled, then hold a fourth set against back-pressure.
        forceReady = 1'b0;
        applyStimulus(0, mk(10, 20, 30));
        applyStimulus(0, mk(1, 1, 1));
        applyStimulus(0, mk(5, 5, 5));
        laneBus = mk(7, 8, 9);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkVal($sformatf("stall-in-ready%0d", c), 33'(inReady[0]), 33'd0);
            checkVal($sformatf("stall-out-valid%0d", c), 33'(outValid[0]), 33'd1);
            checkVal($sformatf("stall-hold%0d", c), {outOvf[0], outData[0]}, {1'b0, 32'd60});
            @(posedge clk);
            #1;
        end
        forceReady = 1'b1;
        applyStimulus(0, mk(7, 8, 9));
        idle(8);

        applyStimulus(1, mk(32'hFF, 32'h01, 32'h00));
        inValid[1] = 1'b0;
        checkOutput("mode0-wrap-w8", 1, 32'h00, 1'b1, 10);
        applyStimulus(2, mk(32'hFF, 32'h01, 32'h00));
        inValid[2] = 1'b0;
        checkOutput("mode1-sat-w8", 2, 32'hFF, 1'b1, 10);
        applyStimulus(3, mk(32'h7F, 32'h01, 32'h00));
        inValid[3] = 1'b0;
        checkOutput("mode2-posclamp", 3, 32'h7F, 1'b1, 10);
        applyStimulus(3, mk(32'h80, 32'hFF, 32'h00));
        inValid[3] = 1'b0;
        checkOutput("mode2-negclamp", 3, 32'h80, 1'b1, 10);
        applyStimulus(3, mk(32'h80, 32'h7F, 32'h01));
        inValid[3] = 1'b0;
        checkOutput("mode2-in-range", 3, 32'h00, 1'b0, 10);
        applyStimulus(6, mk(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF));
        inValid[6] = 1'b0;
        checkOutput("n5-wrap", 6, 32'hFFFB, 1'b1, 10);
        applyStimulus(4, mk(32'h1234ABCD));
        inValid[4] = 1'b0;
        checkOutput("n1-pass", 4, 32'hABCD, 1'b0, 3);
        idle(4);

        // Reset with sets in flight: outputs drop at once and nothing stale emerges afterwards.
        applyStimulus(0, mk(1, 1, 1));
        applyStimulus(0, mk(2, 2, 2));
        applyStimulus(0, mk(3, 3, 3));
        inValid[0] = 1'b0;
        checkVal("valid-before-reset", 33'(outValid[0]), 33'd1);
        rst = 1'b1;
        #1;
        checkVal("reset-drops-valid", 33'(outValid[0]), 33'd0);
        checkVal("reset-clears-data", {outOvf[0], outData[0]}, 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("in-ready-after-release", 33'(inReady[0]), 33'd1);
        @(posedge clk);
        #1;
        idle(6);

        randReady = 1'b1;
        streamRandom(4, 25);
        streamRandom(5, 25);
        streamRandom(6, 25);
        streamRandom(3, 25);
        streamRandom(1, 15);
        streamRandom(2, 15);
        streamRandom(0, 15);
        randReady  = 1'b0;
        forceReady = 1'b1;
        idle(12);

        for (int d = 0; d < 7; d++) begin
            checkVal($sformatf("drained-dut%0d", d), 33'(expQ[d].size()), 33'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
